// File: rtl/alu_exec_unit.sv
// Handshaked single-issue ALU: decodes RV32-style ALU ops, registers result and flags.
// Shifts iterate one bit per clock unless ALU_BARREL_SHIFT_EN is defined (single-cycle barrel shifter).
//
// state | meaning
// IDLE  | no result held, ready for a request
// BUSY  | iterative shift in progress, one bit per clock
// DONE  | result held valid until the consumer takes it
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [3:0]      funct_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      op_code_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      op_code_q, op_code_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  cnt_q, cnt_d;

    logic [3:0]      dec_op;
    logic            dec_ill;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_step;
    logic            accept;
    logic            go_busy;

    assign shamt = op_b_i[SHW-1:0];

    always_comb begin
        dec_op = OP_ILL;
        case (alu_op_i)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct_i[2:0])
                    3'b000: dec_op = funct_i[3] ? OP_SUB : OP_ADD;
                    3'b001: dec_op = funct_i[3] ? OP_ILL : OP_SLL;
                    3'b010: dec_op = funct_i[3] ? OP_ILL : OP_SLT;
                    3'b011: dec_op = funct_i[3] ? OP_ILL : OP_SLTU;
                    3'b100: dec_op = funct_i[3] ? OP_ILL : OP_XOR;
                    3'b101: dec_op = funct_i[3] ? OP_SRA : OP_SRL;
                    3'b110: dec_op = funct_i[3] ? OP_ILL : OP_OR;
                    default: dec_op = funct_i[3] ? OP_ILL : OP_AND;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
    end

    assign dec_ill = (dec_op == OP_ILL);

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_AND:  alu_res = op_a_i & op_b_i;
            OP_OR:   alu_res = op_a_i | op_b_i;
            OP_ADD:  alu_res = op_a_i + op_b_i;
            OP_XOR:  alu_res = op_a_i ^ op_b_i;
            OP_SUB:  alu_res = op_a_i - op_b_i;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL:  alu_res = op_a_i << shamt;
            OP_SRL:  alu_res = op_a_i >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(op_a_i) >>> shamt);
`else
            // Seed value for the iterative shifter; also the final answer for k=0.
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a_i;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign go_busy = 1'b0;
`else
    assign go_busy = ((dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA))
                     && (shamt != '0);
`endif

    always_comb begin
        shift_step = result_q;
        case (op_code_q)
            OP_SLL:  shift_step = {result_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, result_q[XLEN-1:1]};
            OP_SRA:  shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: shift_step = result_q;
        endcase
    end

    assign in_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        op_code_d = op_code_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_BUSY: begin
                result_d = shift_step;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    zero_d  = (shift_step == '0);
                end
            end
            S_DONE: begin
                if (out_ready_i && !in_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // A new request overrides whatever the current state would do.
        if (accept) begin
            op_code_d = dec_op;
            illegal_d = dec_ill;
            if (dec_ill) begin
                result_d = '0;
                zero_d   = 1'b1;
                state_d  = S_DONE;
            end else if (go_busy) begin
                result_d = op_a_i;
                cnt_d    = shamt;
                zero_d   = 1'b0;
                state_d  = S_BUSY;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            op_code_q <= OP_AND;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            op_code_q <= op_code_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign op_code_o   = op_code_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
// Honours ALU_BARREL_SHIFT_EN for the expected shift latency.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      alu_op = '0;
    logic [3:0]      funct = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic [3:0]      op_code;
    logic            zero;
    logic            illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_res;
    logic [3:0]  exp_code;
    logic        exp_ill;
    int          exp_lat;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_op_i    (alu_op),
        .funct_i     (funct),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .op_code_o   (op_code),
        .zero_o      (zero),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] aop, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] c,
                         output logic ill, output int lat);
        int k;
        bit is_shift;
        k = int'(b[4:0]);
        if (aop == 2'b00)      c = 4'b0010;
        else if (aop == 2'b01) c = 4'b0110;
        else if (aop == 2'b11) c = 4'b1111;
        else begin
            case (f[2:0])
                3'b000: c = f[3] ? 4'b0110 : 4'b0010;
                3'b101: c = f[3] ? 4'b0111 : 4'b0101;
                3'b001: c = 4'b0100;
                3'b010: c = 4'b1000;
                3'b011: c = 4'b1001;
                3'b100: c = 4'b0011;
                3'b110: c = 4'b0001;
                default: c = 4'b0000;
            endcase
            if (f[3] && f[2:0] != 3'b000 && f[2:0] != 3'b101) c = 4'b1111;
        end
        ill = (c == 4'b1111);
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << k;
            4'b0101: r = a >> k;
            4'b0110: r = a - b;
            4'b0111: r = 32'($signed(a) >>> k);
            4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1001: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        is_shift = (c == 4'b0100) || (c == 4'b0101) || (c == 4'b0111);
`ifdef ALU_BARREL_SHIFT_EN
        lat = 1;
`else
        lat = is_shift ? 1 + k : 1;
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_op_code"}, op_code, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_illegal"}, illegal, 0);
    endtask

    // Called at 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] aop, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        int w;
        model(aop, f, a, b, exp_res, exp_code, exp_ill, exp_lat);
        alu_op = aop; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_op = 2'($urandom); funct = 4'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (!out_valid && lat < 80) begin
            chk({tag, "_busy_in_ready"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_op_code"}, op_code, exp_code);
        chk({tag, "_zero"}, zero, (exp_res == 0));
        chk({tag, "_illegal"}, illegal, exp_ill);
    endtask

    task automatic hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_result"}, result, exp_res);
            chk({tag, "_hold_code"}, op_code, exp_code);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #1;
        chk({tag, "_retired_valid"}, out_valid, 0);
        chk({tag, "_retired_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [1:0]  r_aop;
        logic [31:0] r_b;
        int          sel;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(2'b10, 4'b1000, 32'd5, 32'd7);
        wait_done("sub_neg");
        retire("sub_neg");

        issue(2'b10, 4'b1101, 32'h8000_0000, 32'd4);
        wait_done("sra4");
        retire("sra4");

        issue(2'b11, 4'b0000, 32'h1234, 32'h1);
        wait_done("ill_aop");
        retire("ill_aop");

        issue(2'b10, 4'b1110, 32'h1234, 32'h1);
        wait_done("ill_funct");
        retire("ill_funct");

        issue(2'b10, 4'b0101, 32'hDEAD_BEEF, 32'h0000_0020);
        wait_done("srl_k0");
        retire("srl_k0");

        issue(2'b10, 4'b0001, 32'h0000_0003, 32'hFFFF_FFFF);
        wait_done("sll_k31");
        retire("sll_k31");

        issue(2'b00, 4'b1111, 32'hFFFF_FFFF, 32'd1);
        wait_done("add_wrap");
        retire("add_wrap");

        issue(2'b00, 4'b0000, 32'd3, 32'd4);
        wait_done("b2b_first");
        hold("b2b_first", 3);
        out_ready = 1'b1;
        issue(2'b00, 4'b0000, 32'd1, 32'd1);
        out_ready = 1'b0;
        wait_done("b2b_second");
        retire("b2b_second");

        issue(2'b10, 4'b0001, 32'd1, 32'd20);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_reset_no_delivery", seen, 0);
        out_ready = 1'b0;

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            r_aop = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            r_b = $urandom;
            if ($urandom_range(0, 1) == 1) r_b = (r_b & 32'hFFFF_FFE0) | 32'($urandom_range(0, 5));
            issue(r_aop, 4'($urandom), $urandom, r_b);
            wait_done("rand");
            hold("rand", $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b1;
                issue(2'b10, 4'b0100, $urandom, $urandom);
                out_ready = 1'b0;
                wait_done("rand_b2b");
            end
            retire("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; SHALL be a power of two >= 8.
REQ-002 Parameter: SHW, default $clog2(XLEN), shift-amount width taken from op_b[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 alu_op  input  2  00 = ADD, 01 = SUB, 10 = decode funct, 11 = illegal.
REQ-008 funct  input  4  bit3 = funct7[5], bits[2:0] = funct3.
REQ-009 op_a, op_b  input  XLEN  operands.
REQ-010 out_valid  output  1  result held valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  registered result.
REQ-013 op_code  output  4  registered selected op: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, illegal 1111.
REQ-014 zero  output  1  registered (result == 0).
REQ-015 illegal  output  1  registered illegal-request flag.

Function
REQ-016 Decode for alu_op=10: funct3 000 -> ADD (bit3=0) or SUB (bit3=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRL (bit3=0) or SRA (bit3=1); 110 OR; 111 AND.
REQ-017 alu_op=11, or bit3=1 with funct3 not in {000,101}, SHALL be illegal: result 0, op_code 1111, illegal 1, zero 1.
REQ-018 Arithmetic SHALL wrap modulo 2^XLEN; SLT compares signed, SLTU unsigned; both yield 1 or 0 zero-extended.
REQ-019 SRA SHALL replicate op_a[XLEN-1]; SLL/SRL fill with 0; only op_b[SHW-1:0] is used.
REQ-020 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-021 Accept occurs on an edge with in_valid and in_ready high; inputs are sampled only then.
REQ-022 Non-shift or illegal accept: next state DONE, result registered; out_valid high in cycle N+1 (N = accept cycle).
REQ-023 Shift accept with amount k: k=0 -> DONE with result=op_a; k>0 -> BUSY, one bit shifted per edge, DONE after k BUSY edges; out_valid high in cycle N+1+k.
REQ-024 DONE: result/op_code/zero/illegal SHALL stay stable while out_ready is low; out_ready high with no accept -> IDLE, out_valid low next cycle.
REQ-025 DONE with out_ready and in_valid on the same edge: old result retired and new request accepted on that edge; no bubble for non-shift ops.
REQ-026 out_valid SHALL be high exactly in DONE; in_ready SHALL be low in BUSY.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready 1, out_valid 0, result 0, op_code 0000, zero 0, illegal 0, shift counter 0.
REQ-028 Reset asserted during BUSY or DONE SHALL discard the operation; no result is delivered afterwards.
REQ-029 First accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ALU_BARREL_SHIFT_EN: defined -> shifts complete combinationally like other ops, BUSY is never entered, latency 1 for all ops.
REQ-031 Macro ALU_BARREL_SHIFT_EN undefined -> iterative shifting per REQ-023; all other behaviour identical.

Verification
REQ-032 XLEN=32, alu_op=10 funct=1000, a=5 b=7, out_ready=1 -> cycle N+1: result 0xFFFFFFFE, op_code 0110, zero 0.
REQ-033 Iterative build, funct=1101 (SRA), a=0x80000000 b=4 -> out_valid first at N+5, result 0xF8000000; in_ready low in N+1..N+4.
REQ-034 alu_op=11 -> result 0, op_code 1111, illegal 1, zero 1 at N+1; funct=1110 with alu_op=10 -> same.
REQ-035 out_ready held low 3 cycles after DONE -> result unchanged, in_ready low; out_ready and in_valid raised together (ADD 1+1) -> back-to-back accept, next result 2 at following cycle.
REQ-036 rst_n pulsed low during BUSY of SLL b=20 -> outputs zero immediately, no out_valid after release; barrel build: SLL b=20 -> out_valid at N+1.
